// File: rtl/demux_scan_controller_pkg.sv
// rtl/demux_scan_controller_pkg.sv - shared types and helpers for the demux scan controller
// Purpose: FSM state encoding and channel/select helpers used by the scan controller.
// Ports:   none (package).
package scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_DWELL = 2'd2;

  // The demux routes input_sel=s to Nout[7-s], so channel k needs select 7-k.
  function automatic logic [2:0] chan_to_sel(input logic [2:0] k);
    return 3'd7 - k;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_scan_controller_if.sv
// rtl/demux_scan_controller_if.sv - control and demux-drive bundle of the scan controller
// Purpose: groups scan control inputs and demux/status outputs.
// Signals: enable, chan_mask (to controller); dmx_a, dmx_sel, active_chan,
//          chan_active, frame_start, frame_done (from controller).
// Modports: slave = controller side, master = host/driver side.
interface demux_scan_controller_if;

  logic       enable;
  logic [7:0] chan_mask;
  logic       dmx_a;
  logic [2:0] dmx_sel;
  logic [2:0] active_chan;
  logic       chan_active;
  logic       frame_start;
  logic       frame_done;

  modport slave (
    input  enable, chan_mask,
    output dmx_a, dmx_sel, active_chan, chan_active, frame_start, frame_done
  );

  modport master (
    output enable, chan_mask,
    input  dmx_a, dmx_sel, active_chan, chan_active, frame_start, frame_done
  );

endinterface

// File: rtl/demux_scan_controller_picker.sv
// rtl/demux_scan_controller_picker.sv - finds the next enabled channel above the current one
// Purpose: combinational search for the lowest set mask bit strictly above cur.
// Ports:   mask (8) enabled channels, cur (3) current index,
//          next_idx (3) next enabled index (cur when none), found (1) a next index exists.
module next_channel_picker (
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] next_idx,
  output logic       found
);

  // Descending scan so the lowest qualifying bit is the one left standing.
  always_comb begin
    found    = 1'b0;
    next_idx = cur;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/demux_scan_controller.sv
// rtl/demux_scan_controller.sv - blank/dwell time-multiplexing sequencer for a 1-to-8 active-low demux
// Purpose: walks the enabled channels of a latched mask, holding BLANK dead cycles
//          (dmx_a=1, select already moved) then DWELL active cycles (dmx_a=0) per channel.
// Ports:   clk, rst_n (async, active-low);
//          bus.enable, bus.chan_mask in; bus.dmx_a, bus.dmx_sel, bus.active_chan,
//          bus.chan_active, bus.frame_start, bus.frame_done out (all registered).
module demux_scan_controller
  import scan_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int BLANK = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_scan_controller_if.slave bus
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
  // With no blanking the BLANK state is skipped entirely.
  localparam state_t FIRST_STATE = (BLANK == 0) ? ST_DWELL : ST_BLANK;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mask_q, mask_d;
  logic [2:0]    chan_q, chan_d;
  logic          fs_d, fd_d;

  logic          dmx_a_q;
  logic [2:0]    sel_q;
  logic          chan_active_q;
  logic          fs_q, fd_q;

  logic [2:0]    pick_next;
  logic          pick_found;

  next_channel_picker u_picker (
    .mask     (mask_q),
    .cur      (chan_q),
    .next_idx (pick_next),
    .found    (pick_found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    chan_d  = chan_q;
    fs_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.enable && (bus.chan_mask != 8'd0)) begin
          mask_d  = bus.chan_mask;
          chan_d  = lowest_set(bus.chan_mask);
          state_d = FIRST_STATE;
          fs_d    = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DWELL: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (pick_found) begin
            chan_d  = pick_next;
            state_d = FIRST_STATE;
          end else if (bus.chan_mask != 8'd0) begin
            // Frame boundary: the only point where a new mask is accepted.
            mask_d  = bus.chan_mask;
            chan_d  = lowest_set(bus.chan_mask);
            state_d = FIRST_STATE;
            fs_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // frame_done is registered, so it is raised on the edge that enters the last
  // dwell cycle of a channel with no enabled channel above it.
  always_comb begin
    fd_d = (state_d == ST_DWELL) && (cnt_d == DWELL_LAST) &&
           (((mask_d >> chan_d) >> 1) == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mask_q        <= '0;
      chan_q        <= '0;
      dmx_a_q       <= 1'b1;
      sel_q         <= 3'b111;
      chan_active_q <= 1'b0;
      fs_q          <= 1'b0;
      fd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      chan_q        <= chan_d;
      // Select follows the channel on BLANK entry; it cannot move inside a dwell
      // because chan_d only changes on the dwell's last cycle.
      sel_q         <= chan_to_sel(chan_d);
      dmx_a_q       <= (state_d != ST_DWELL);
      chan_active_q <= (state_d == ST_DWELL);
      fs_q          <= fs_d;
      fd_q          <= fd_d;
    end
  end

  assign bus.dmx_a       = dmx_a_q;
  assign bus.dmx_sel     = sel_q;
  assign bus.active_chan = chan_q;
  assign bus.chan_active = chan_active_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_demux_scan_controller.sv
// tb/tb_demux_scan_controller.sv - directed self-checking bench for demux_scan_controller
module tb_demux_scan_controller;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int SLOT = DW + BL;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  demux_scan_controller_if bus ();

  demux_scan_controller #(.DWELL(DW), .BLANK(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = clk_run ? ~clk : clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks ncyc consecutive cycles of a frame of mask m, starting at frame cycle start.
  // Cycle j: slot j/SLOT is the (j/SLOT)-th enabled channel in ascending order,
  // first BL cycles of a slot blank, the rest dwell.
  task automatic scan_check(input logic [7:0] m, input int start, input int ncyc);
    int chans[$];
    int period, j, ch, p;
    logic [2:0] ch3;
    chans.delete();
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    period = chans.size() * SLOT;
    for (int k = 0; k < ncyc; k++) begin
      j   = (start + k) % period;
      ch  = chans[j / SLOT];
      p   = j % SLOT;
      ch3 = 3'(ch);
      check("dmx_a",       {7'd0, bus.dmx_a},       {7'd0, (p < BL)});
      check("dmx_sel",     {5'd0, bus.dmx_sel},     {5'd0, 3'd7 - ch3});
      check("active_chan", {5'd0, bus.active_chan}, {5'd0, ch3});
      check("chan_active", {7'd0, bus.chan_active}, {7'd0, (p >= BL)});
      check("frame_start", {7'd0, bus.frame_start}, {7'd0, (j == 0)});
      check("frame_done",  {7'd0, bus.frame_done},  {7'd0, (j == period - 1)});
      @(negedge clk);
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.chan_mask = 8'h00;

    // 1: asynchronous reset with no clock running
    #1 rst_n = 1'b0;
    #2;
    check("rst_dmx_a",       {7'd0, bus.dmx_a},       8'd1);
    check("rst_dmx_sel",     {5'd0, bus.dmx_sel},     8'd7);
    check("rst_active_chan", {5'd0, bus.active_chan}, 8'd0);
    check("rst_chan_active", {7'd0, bus.chan_active}, 8'd0);
    check("rst_frame_start", {7'd0, bus.frame_start}, 8'd0);
    check("rst_frame_done",  {7'd0, bus.frame_done},  8'd0);

    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_dmx_a", {7'd0, bus.dmx_a}, 8'd1);

    // 2: all eight channels, two full frames
    bus.chan_mask = 8'hFF;
    bus.enable    = 1'b1;
    @(negedge clk);
    scan_check(8'hFF, 0, 2 * 8 * SLOT);

    // 4: shrink mask during channel 3; current frame still finishes through channel 7
    scan_check(8'hFF, 0, 3 * SLOT + 3);
    bus.chan_mask = 8'h01;
    scan_check(8'hFF, 3 * SLOT + 3, 8 * SLOT - (3 * SLOT + 3));
    scan_check(8'h01, 0, 3 * SLOT);

    // 3: sparse mask 1010_0100 takes effect at the next frame boundary
    bus.chan_mask = 8'hA4;
    scan_check(8'h01, 0, SLOT);
    scan_check(8'hA4, 0, 2 * 3 * SLOT);

    // 5: drop enable during the dwell of channel 3
    bus.chan_mask = 8'hFF;
    scan_check(8'hA4, 0, 3 * SLOT);
    scan_check(8'hFF, 0, 3 * SLOT + BL);
    check("ch3_dwell_dmx_a", {7'd0, bus.dmx_a}, 8'd0);
    bus.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("dis_dmx_a",       {7'd0, bus.dmx_a},       8'd1);
      check("dis_chan_active", {7'd0, bus.chan_active}, 8'd0);
      check("dis_frame_done",  {7'd0, bus.frame_done},  8'd0);
      check("dis_frame_start", {7'd0, bus.frame_start}, 8'd0);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    scan_check(8'hFF, 0, 2 * SLOT);

    // 6: empty mask keeps the controller idle
    bus.enable = 1'b0;
    @(negedge clk);
    bus.chan_mask = 8'h00;
    bus.enable    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("empty_dmx_a",       {7'd0, bus.dmx_a},       8'd1);
      check("empty_chan_active", {7'd0, bus.chan_active}, 8'd0);
      check("empty_frame_start", {7'd0, bus.frame_start}, 8'd0);
      check("empty_frame_done",  {7'd0, bus.frame_done},  8'd0);
    end

    // 6: reset asserted mid-dwell releases the demux without a clock edge
    bus.chan_mask = 8'h01;
    @(negedge clk);
    check("start_frame_start", {7'd0, bus.frame_start}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_dmx_a", {7'd0, bus.dmx_a}, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dmx_a",       {7'd0, bus.dmx_a},       8'd1);
    check("async_rst_chan_active", {7'd0, bus.chan_active}, 8'd0);
    check("async_rst_dmx_sel",     {5'd0, bus.dmx_sel},     8'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
